// File: rtl/otter_mmio_pkg.sv
// rtl/otter_mmio_pkg.sv - OTTER IOBUS address map, UART status bit indices and serializer states.
package otter_mmio_pkg;

  localparam logic [31:0] SWITCHES_AD  = 32'h1100_0000;
  localparam logic [31:0] LEDS_AD      = 32'h1100_0020;
  localparam logic [31:0] SSEG_AD      = 32'h1100_0040;
  localparam logic [31:0] UART_DATA_AD = 32'h1100_0060;
  localparam logic [31:0] UART_STAT_AD = 32'h1100_0064;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_OVF     = 3;
  localparam int ST_PARITY  = 4;
  localparam int ST_CNT_LSB = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_tx_state_t;

endpackage

// File: rtl/iobus_uart_tx_if.sv
// rtl/iobus_uart_tx_if.sv - IOBUS write port and read-data return seen by the UART transmitter.
interface iobus_uart_tx_if;
  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] RD_DATA;

  modport master (output IOBUS_ADDR, IOBUS_OUT, IOBUS_WR, input RD_DATA);
  modport slave  (input IOBUS_ADDR, IOBUS_OUT, IOBUS_WR, output RD_DATA);
endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - Synchronous FIFO with fall-through read data and occupancy count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Power-of-two depth lets the pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/iobus_uart_tx.sv
// rtl/iobus_uart_tx.sv - IOBUS-mapped 8N1 UART transmitter with byte FIFO and status register.
// Define UART_TX_PARITY_EN to insert an even parity bit between the data bits and stop.
module iobus_uart_tx
  import otter_mmio_pkg::*;
#(
  parameter int          CLK_HZ     = 50_000_000,
  parameter int          BAUD       = 115_200,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] DATA_AD    = UART_DATA_AD,
  parameter logic [31:0] STAT_AD    = UART_STAT_AD
) (
  input  logic           CLK,
  input  logic           RST,
  iobus_uart_tx_if.slave bus,
  output logic           TX,
  output logic           TX_BUSY
);
  localparam int DIV  = (CLK_HZ + BAUD / 2) / BAUD;
  localparam int BW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CNTW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(DIV - 1);
`ifdef UART_TX_PARITY_EN
  localparam logic PARITY_EN = 1'b1;
`else
  localparam logic PARITY_EN = 1'b0;
`endif

  logic            data_wr, stat_wr;
  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]      fifo_rdata;
  logic [CNTW-1:0] fifo_count;
  logic            baud_done, start_frame;
  logic            unused_wdata_hi;
  logic [31:0]     status;

  uart_tx_state_t  state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic            ovf_q, ovf_d;
`ifdef UART_TX_PARITY_EN
  logic            par_q, par_d;
`endif

  assign data_wr         = bus.IOBUS_WR && (bus.IOBUS_ADDR == DATA_AD);
  assign stat_wr         = bus.IOBUS_WR && (bus.IOBUS_ADDR == STAT_AD);
  assign fifo_push       = data_wr && !fifo_full;
  assign baud_done       = (baud_q == BAUD_LAST);
  assign unused_wdata_hi = ^bus.IOBUS_OUT[31:8];

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (bus.IOBUS_OUT[7:0]),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A rejected push outranks a status-write clear.
  always_comb begin
    ovf_d = ovf_q;
    if (stat_wr)              ovf_d = 1'b0;
    if (data_wr && fifo_full) ovf_d = 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q + BW'(1);
    bit_d       = bit_q;
    shift_d     = shift_q;
    tx_d        = tx_q;
    fifo_pop    = 1'b0;
    start_frame = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d       = par_q;
`endif
    case (state_q)
      IDLE: begin
        baud_d      = '0;
        tx_d        = 1'b1;
        start_frame = !fifo_empty;
      end
      START: if (baud_done) begin
        baud_d  = '0;
        state_d = DATA;
        tx_d    = shift_q[0];
      end
      DATA: if (baud_done) begin
        baud_d  = '0;
        shift_d = {1'b0, shift_q[7:1]};
        if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_d = PARITY;
          tx_d    = par_q;
`else
          state_d = STOP;
          tx_d    = 1'b1;
`endif
        end else begin
          bit_d = bit_q + 3'd1;
          tx_d  = shift_q[1];
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: if (baud_done) begin
        baud_d  = '0;
        state_d = STOP;
        tx_d    = 1'b1;
      end
`endif
      STOP: if (baud_done) begin
        baud_d      = '0;
        state_d     = IDLE;
        tx_d        = 1'b1;
        start_frame = !fifo_empty;
      end
      default: begin
        baud_d  = '0;
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
    // Loading from STOP as well as IDLE is what makes back-to-back frames gapless.
    if (start_frame) begin
      fifo_pop = 1'b1;
      shift_d  = fifo_rdata;
      bit_d    = '0;
      baud_d   = '0;
      state_d  = START;
      tx_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d    = ^fifo_rdata;
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      ovf_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign TX      = tx_q;
  assign TX_BUSY = (state_q != IDLE) || !fifo_empty;

  always_comb begin
    status                     = '0;
    status[ST_FULL]            = fifo_full;
    status[ST_EMPTY]           = fifo_empty;
    status[ST_BUSY]            = TX_BUSY;
    status[ST_OVF]             = ovf_q;
    status[ST_PARITY]          = PARITY_EN;
    status[ST_CNT_LSB +: 4]    = 4'(fifo_count);
  end

  assign bus.RD_DATA = (bus.IOBUS_ADDR == STAT_AD) ? status : 32'b0;

endmodule

// File: tb/tb_iobus_uart_tx.sv
// tb/tb_iobus_uart_tx.sv - Self-checking bench for iobus_uart_tx against a frame-level reference model.
module tb_iobus_uart_tx;
  localparam int DEPTH = 4;
  localparam int DIV   = 16;
`ifdef UART_TX_PARITY_EN
  localparam int          FRAME = 11 * DIV;
  localparam logic [31:0] PBIT  = 32'h10;
`else
  localparam int          FRAME = 10 * DIV;
  localparam logic [31:0] PBIT  = 32'h0;
`endif
  localparam logic [31:0] DATA_AD  = 32'h1100_0060;
  localparam logic [31:0] STAT_AD  = 32'h1100_0064;
  localparam logic [31:0] OTHER_AD = 32'h1100_0020;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx, busy;

  iobus_uart_tx_if bus ();

  iobus_uart_tx #(
    .CLK_HZ     (16),
    .BAUD       (1),
    .FIFO_DEPTH (DEPTH),
    .DATA_AD    (DATA_AD),
    .STAT_AD    (STAT_AD)
  ) dut (
    .CLK     (clk),
    .RST     (rst),
    .bus     (bus),
    .TX      (tx),
    .TX_BUSY (busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  // Reference: FIFO contents as a queue, current frame as (byte, cycle position).
  byte unsigned mq[$];
  byte unsigned exp_done[$];
  bit           m_active = 1'b0;
  int           m_pos    = 0;
  logic [7:0]   m_cur    = 8'h0;
  bit           m_ovf    = 1'b0;

  logic tx_hist[int];
  logic busy_hist[int];

  byte unsigned rx_q[$];
  bit           d_in  = 1'b0;
  int           d_cnt = 0;
  logic [7:0]   d_byte = 8'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  function automatic logic exp_tx();
    int slot;
    if (!m_active) return 1'b1;
    slot = m_pos / DIV;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return m_cur[slot-1];
`ifdef UART_TX_PARITY_EN
    if (slot == 9) return ^m_cur;
`endif
    return 1'b1;
  endfunction

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s       = PBIT;
    s[0]    = (mq.size() == DEPTH);
    s[1]    = (mq.size() == 0);
    s[2]    = m_active || (mq.size() != 0);
    s[3]    = m_ovf;
    s[11:8] = 4'(mq.size());
    return s;
  endfunction

  always @(posedge clk) begin
    bit full, dwr, swr;
    cyc++;
    if (rst) begin
      mq.delete();
      m_active = 1'b0;
      m_pos    = 0;
      m_ovf    = 1'b0;
    end else begin
      full = (mq.size() == DEPTH);
      dwr  = bus.IOBUS_WR && (bus.IOBUS_ADDR == DATA_AD);
      swr  = bus.IOBUS_WR && (bus.IOBUS_ADDR == STAT_AD);
      if (swr) m_ovf = 1'b0;
      if (dwr && full) m_ovf = 1'b1;
      if (m_active && m_pos < FRAME - 1) begin
        m_pos++;
      end else begin
        if (m_active) exp_done.push_back(m_cur);
        if (mq.size() > 0) begin
          m_cur    = mq.pop_front();
          m_active = 1'b1;
          m_pos    = 0;
        end else begin
          m_active = 1'b0;
        end
      end
      if (dwr && !full) mq.push_back(bus.IOBUS_OUT[7:0]);
    end
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      chk("tx", 32'(tx), 32'(exp_tx()));
      chk("busy", 32'(busy), 32'(exp_status() >> 2) & 32'h1);
      chk("rd_data", bus.RD_DATA, (bus.IOBUS_ADDR == STAT_AD) ? exp_status() : 32'h0);
      tx_hist[cyc]   = tx;
      busy_hist[cyc] = busy;
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      d_in = 1'b0;
    end else if (!d_in) begin
      if (tx === 1'b0) begin
        d_in  = 1'b1;
        d_cnt = 0;
      end
    end else begin
      d_cnt++;
      if (d_cnt >= DIV && d_cnt < 9 * DIV && (d_cnt % DIV) == DIV / 2)
        d_byte[(d_cnt / DIV) - 1] = tx;
      if (d_cnt == FRAME - DIV / 2) begin
        rx_q.push_back(d_byte);
        d_in = 1'b0;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [31:0] a, input logic [7:0] d, output int k);
    bus.IOBUS_WR   = 1'b1;
    bus.IOBUS_ADDR = a;
    bus.IOBUS_OUT  = {24'($urandom()), d};
    step(1);
    k              = cyc;
    bus.IOBUS_WR   = 1'b0;
    bus.IOBUS_ADDR = 32'h0;
  endtask

  task automatic wait_idle(input int bound, output int endc);
    int n = 0;
    while (busy && n < bound) begin
      step(1);
      n++;
    end
    checks++;
    if (busy) begin
      failures++;
      $display("FAIL wait_idle_timeout cyc=%0d actual=busy required=idle", cyc);
    end
    endc = cyc;
  endtask

  task automatic read_stat(input string name, input logic [31:0] exp);
    bus.IOBUS_ADDR = STAT_AD;
    #1;
    chk(name, bus.RD_DATA, exp);
    bus.IOBUS_ADDR = 32'h0;
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, e, r;
    int a5_bits[8] = '{1, 0, 1, 0, 0, 1, 0, 1};
    bus.IOBUS_WR   = 1'b0;
    bus.IOBUS_ADDR = 32'h0;
    bus.IOBUS_OUT  = 32'h0;

    // Reset and idle
    step(3);
    rst = 1'b0;
    step(100);
    chk("t1_tx", 32'(tx), 32'h1);
    chk("t1_busy", 32'(busy), 32'h0);
    read_stat("t1_status", 32'h2 | PBIT);

    // Single byte A5
    write(DATA_AD, 8'hA5, k);
    wait_idle(400, e);
    chk("t2_frame_end", 32'(e), 32'(k + FRAME + 1));
    chk("t2_pre_start", 32'(tx_hist[k]), 32'h1);
    chk("t2_start_first", 32'(tx_hist[k+1]), 32'h0);
    chk("t2_start_last", 32'(tx_hist[k+16]), 32'h0);
    for (int i = 0; i < 8; i++)
      chk($sformatf("t2_bit%0d", i), 32'(tx_hist[k + 1 + DIV*(i+1) + DIV/2]), 32'(a5_bits[i]));
    chk("t2_stop", 32'(tx_hist[k + 1 + FRAME - DIV]), 32'h1);
    chk("t2_busy_last", 32'(busy_hist[k + FRAME]), 32'h1);

    // Three back-to-back bytes
    rx_q.delete();
    write(DATA_AD, 8'h01, k);
    write(DATA_AD, 8'h02, e);
    write(DATA_AD, 8'h03, e);
    wait_idle(1000, e);
    chk("t3_span", 32'(e - (k + 1)), 32'(3 * FRAME));
    chk("t3_count", 32'(rx_q.size()), 32'd3);
    for (int i = 0; i < 3 && i < rx_q.size(); i++)
      chk($sformatf("t3_byte%0d", i), 32'(rx_q[i]), 32'(i + 1));

    // Overflow: six writes, five accepted
    rx_q.delete();
    for (int i = 0; i < 6; i++) write(DATA_AD, 8'h10 + 8'(i), k);
    read_stat("t4_status_full", 32'h0000_040D | PBIT);
    write(STAT_AD, 8'h00, k);
    read_stat("t4_status_clr", 32'h0000_0405 | PBIT);
    wait_idle(2000, e);
    chk("t4_count", 32'(rx_q.size()), 32'd5);
    for (int i = 0; i < 5 && i < rx_q.size(); i++)
      chk($sformatf("t4_byte%0d", i), 32'(rx_q[i]), 32'(8'h10 + i));

    // Reset mid-frame
    rx_q.delete();
    write(DATA_AD, 8'h3C, k);
    while (cyc < k + 40) step(1);
    rst = 1'b1;
    step(1);
    chk("t5_tx", 32'(tx), 32'h1);
    read_stat("t5_status", 32'h2 | PBIT);
    rst = 1'b0;
    step(300);
    chk("t5_no_residual", 32'(rx_q.size()), 32'd0);
    chk("t5_tx_idle", 32'(tx), 32'h1);

`ifdef UART_TX_PARITY_EN
    write(DATA_AD, 8'h07, k);
    step(5);
    read_stat("t6_status", 32'h0000_0016);
    wait_idle(400, e);
    chk("t6_parity_bit", 32'(tx_hist[k + 1 + 9*DIV + DIV/2]), 32'h1);
    chk("t6_frame_end", 32'(e), 32'(k + 177));
`endif

    // Random traffic against the reference model
    rx_q.delete();
    exp_done.delete();
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 999);
      bus.IOBUS_WR  = 1'b0;
      bus.IOBUS_OUT = $urandom();
      rst = (r < 3) && !m_active;
      case ($urandom_range(0, 2))
        0:       bus.IOBUS_ADDR = DATA_AD;
        1:       bus.IOBUS_ADDR = STAT_AD;
        default: bus.IOBUS_ADDR = OTHER_AD;
      endcase
      if (r >= 10 && r < 40) begin
        bus.IOBUS_WR   = 1'b1;
        bus.IOBUS_ADDR = DATA_AD;
      end else if (r >= 40 && r < 46) begin
        bus.IOBUS_WR   = 1'b1;
        bus.IOBUS_ADDR = STAT_AD;
      end else if (r >= 46 && r < 56) begin
        bus.IOBUS_WR   = 1'b1;
        bus.IOBUS_ADDR = OTHER_AD;
      end
      step(1);
    end
    rst            = 1'b0;
    bus.IOBUS_WR   = 1'b0;
    bus.IOBUS_ADDR = 32'h0;
    wait_idle(8000, e);
    step(2);
    chk("rand_count", 32'(rx_q.size()), 32'(exp_done.size()));
    for (int i = 0; i < rx_q.size() && i < exp_done.size(); i++)
      chk($sformatf("rand_byte%0d", i), 32'(rx_q[i]), 32'(exp_done[i]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
